// File: rtl/vc_avail_valid_tx_buffer.sv
// Multi-VC transmit buffer: per-VC FIFOs drained round-robin onto an avail/valid NoC link.
// Optional per-VC sent-flit counters are enabled with VC_AVAIL_VALID_TX_STATS_EN.
module vc_avail_valid_tx_buffer #(
    parameter int FlitWidth               = 64,
    parameter int NumberOfVirtualChannels = 4,
    parameter int FifoDepth               = 4,
    localparam int VcIdWidth = (NumberOfVirtualChannels > 1) ? $clog2(NumberOfVirtualChannels) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [FlitWidth-1:0]               s_data,
    input  logic [VcIdWidth-1:0]               s_vc,
    output logic                               valid,
    output logic [FlitWidth-1:0]               data,
    output logic [NumberOfVirtualChannels-1:0] vc,
    input  logic [NumberOfVirtualChannels-1:0] avail
`ifdef VC_AVAIL_VALID_TX_STATS_EN
    ,
    output logic [NumberOfVirtualChannels*16-1:0] sent_count
`endif
);

    localparam int N       = NumberOfVirtualChannels;
    localparam int AddrW   = $clog2(FifoDepth);
    localparam int PtrW    = AddrW + 1;
    localparam int VcSpace = 1 << VcIdWidth;

    logic [FlitWidth-1:0] mem    [N][FifoDepth];
    logic [PtrW-1:0]      wr_ptr [N];
    logic [PtrW-1:0]      rd_ptr [N];

    logic [N-1:0]         empty;
    logic [N-1:0]         full;
    logic [N-1:0]         eligible;
    logic [N-1:0]         push;
    logic [N-1:0]         pop;
    logic [VcSpace-1:0]   full_ext;

    logic [VcIdWidth-1:0] rr_ptr;
    logic [VcIdWidth-1:0] rr_next;
    logic [VcIdWidth-1:0] grant_idx;
    logic [VcIdWidth-1:0] cand;
    logic                 grant_any;
    logic [FlitWidth-1:0] grant_data;

    always_comb begin
        for (int v = 0; v < N; v++) begin
            empty[v] = (wr_ptr[v] == rd_ptr[v]);
            full[v]  = (wr_ptr[v][PtrW-1] != rd_ptr[v][PtrW-1]) &&
                       (wr_ptr[v][AddrW-1:0] == rd_ptr[v][AddrW-1:0]);
        end
        eligible = ~empty & avail;
    end

    // VC ids beyond the configured count map to a permanently "full" slot, so they are never accepted.
    always_comb begin
        full_ext = '1;
        for (int v = 0; v < N; v++) full_ext[v] = full[v];
        s_ready = !full_ext[s_vc];
        for (int v = 0; v < N; v++) push[v] = s_valid && s_ready && (s_vc == VcIdWidth'(v));
    end

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = rr_ptr;
        for (int i = 0; i < N; i++) begin
            if (!grant_any && eligible[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
            cand = (cand == VcIdWidth'(N - 1)) ? '0 : cand + 1'b1;
        end
        pop = '0;
        if (grant_any) pop[grant_idx] = 1'b1;
        rr_next = (grant_idx == VcIdWidth'(N - 1)) ? '0 : grant_idx + 1'b1;
    end

    always_comb begin
        grant_data = '0;
        for (int v = 0; v < N; v++)
            if (pop[v]) grant_data = mem[v][rd_ptr[v][AddrW-1:0]];
    end

    // FIFO storage is data only and carries no reset.
    always_ff @(posedge clk) begin
        for (int v = 0; v < N; v++)
            if (push[v]) mem[v][wr_ptr[v][AddrW-1:0]] <= s_data;
    end

    // Link output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < N; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
            end
            rr_ptr <= '0;
            valid  <= 1'b0;
            vc     <= '0;
            data   <= '0;
        end else begin
            for (int v = 0; v < N; v++) begin
                if (push[v]) wr_ptr[v] <= wr_ptr[v] + 1'b1;
                if (pop[v])  rd_ptr[v] <= rd_ptr[v] + 1'b1;
            end
            valid <= grant_any;
            vc    <= pop;
            if (grant_any) begin
                data   <= grant_data;
                rr_ptr <= rr_next;
            end
        end
    end

`ifdef VC_AVAIL_VALID_TX_STATS_EN
    logic [15:0] cnt [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < N; v++) cnt[v] <= '0;
        end else begin
            for (int v = 0; v < N; v++)
                if (valid && vc[v] && (cnt[v] != 16'hFFFF)) cnt[v] <= cnt[v] + 16'd1;
        end
    end

    always_comb begin
        for (int v = 0; v < N; v++) sent_count[v*16 +: 16] = cnt[v];
    end
`endif

endmodule

// File: tb/tb_vc_avail_valid_tx_buffer.sv
// Scoreboard bench for vc_avail_valid_tx_buffer: accepted flits are queued as expectations
// and matched per VC against link output; covers the optional VC_AVAIL_VALID_TX_STATS_EN port.
module tb_vc_avail_valid_tx_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;
    logic [1:0]  s_vc;
    logic        valid;
    logic [63:0] data;
    logic [3:0]  vc;
    logic [3:0]  avail;
`ifdef VC_AVAIL_VALID_TX_STATS_EN
    logic [63:0] sent_count;
`endif

    typedef struct {
        int          vc;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    vc_avail_valid_tx_buffer #(
        .FlitWidth(64),
        .NumberOfVirtualChannels(4),
        .FifoDepth(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .s_vc(s_vc),
        .valid(valid),
        .data(data),
        .vc(vc),
        .avail(avail)
`ifdef VC_AVAIL_VALID_TX_STATS_EN
        ,
        .sent_count(sent_count)
`endif
    );

    always #5 clk = ~clk;

    // One clock: record an accepted flit in the scoreboard, then advance to just after the edge.
    task automatic tick();
        @(negedge clk);
        if (s_valid && s_ready) exp_q.push_back('{vc: int'(s_vc), data: s_data});
        @(posedge clk);
        #1;
    endtask

    // Pop the oldest expected flit on the VC named by a one-hot code.
    task automatic take_exp(input logic [3:0] oh, output bit found, output logic [63:0] d);
        int hit;
        hit   = -1;
        found = 1'b0;
        d     = '0;
        for (int i = 0; i < exp_q.size(); i++)
            if (hit < 0 && (4'b0001 << exp_q[i].vc) == oh) hit = i;
        if (hit >= 0) begin
            found = 1'b1;
            d     = exp_q[hit].data;
            exp_q.delete(hit);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_vc    = '0;
        s_data  = '0;
        avail   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic push_flit(input logic [1:0] v, input logic [63:0] d);
        s_valid = 1'b1;
        s_vc    = v;
        s_data  = d;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_vc = 2'd0; s_data = '0; avail = '0;
        #1;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_checks++; if (vc !== 4'b0000) begin n_fail++; $display("FAIL reset_vc: got %b want 0000", vc); end
        n_checks++; if (data !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data); end
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
`ifdef VC_AVAIL_VALID_TX_STATS_EN
        n_checks++; if (sent_count !== 64'h0) begin n_fail++; $display("FAIL reset_sent_count: got %h want 0", sent_count); end
`endif
        do_reset();
    endtask

    task automatic test_single();
        bit          found;
        logic [63:0] ed;
        do_reset();
        avail = 4'b1111;
        push_flit(2'd2, 64'hA5);
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got valid=%b want 0", valid); end
        tick();
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", valid); end
        n_checks++; if (vc !== 4'b0100) begin n_fail++; $display("FAIL single_vc: got %b want 0100", vc); end
        n_checks++; if (data !== 64'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", data); end
        take_exp(vc, found, ed);
        n_checks++; if (!found || data !== ed) begin n_fail++; $display("FAIL single_sb: got %h want %h found=%0d", data, ed, found); end
        tick();
        n_checks++; if (valid !== 1'b0 || vc !== 4'b0000) begin n_fail++; $display("FAIL single_after: got valid=%b vc=%b want 0/0000", valid, vc); end
    endtask

    task automatic test_fill();
        bit          found;
        logic [63:0] ed;
        do_reset();
        for (int i = 0; i < 4; i++) push_flit(2'd0, 64'h100 + 64'(i));
        s_valid = 1'b1; s_vc = 2'd0; #1;
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready: got %b want 0", s_ready); end
        s_valid = 1'b0; s_vc = 2'd1; #1;
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL fill_other_ready: got %b want 1", s_ready); end
        n_checks++; if (exp_q.size() != 4) begin n_fail++; $display("FAIL fill_accepted: got %0d want 4", exp_q.size()); end
        avail = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (valid !== 1'b1 || vc !== 4'b0001) begin n_fail++; $display("FAIL fill_out[%0d]: got valid=%b vc=%b want 1/0001", i, valid, vc); end
            take_exp(vc, found, ed);
            n_checks++; if (!found || data !== ed || data !== 64'h100 + 64'(i)) begin n_fail++; $display("FAIL fill_data[%0d]: got %h want %h", i, data, 64'h100 + 64'(i)); end
        end
        tick();
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL fill_drained: got valid=%b want 0", valid); end
    endtask

    task automatic test_round_robin();
        bit          found;
        logic [63:0] ed;
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int v = 0; v < 4; v++) push_flit(2'(v), 64'h200 + 64'(r * 16 + v));
        avail = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++; if (valid !== 1'b1 || vc !== (4'b0001 << (k % 4))) begin n_fail++; $display("FAIL rr_vc[%0d]: got valid=%b vc=%b want 1/%b", k, valid, vc, 4'b0001 << (k % 4)); end
            take_exp(vc, found, ed);
            n_checks++; if (!found || data !== ed) begin n_fail++; $display("FAIL rr_data[%0d]: got %h want %h found=%0d", k, data, ed, found); end
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rr_leftover: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_avail_mask();
        bit          found;
        logic [63:0] ed;
        do_reset();
        push_flit(2'd0, 64'h400); push_flit(2'd0, 64'h401);
        push_flit(2'd1, 64'h410); push_flit(2'd1, 64'h411);
        avail = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k < 2) begin
                n_checks++; if (valid !== 1'b1 || vc !== 4'b0010) begin n_fail++; $display("FAIL mask_vc1[%0d]: got valid=%b vc=%b want 1/0010", k, valid, vc); end
                take_exp(vc, found, ed);
                n_checks++; if (!found || data !== ed) begin n_fail++; $display("FAIL mask_data1[%0d]: got %h want %h", k, data, ed); end
            end else begin
                n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL mask_hold[%0d]: got valid=%b vc=%b want 0", k, valid, vc); end
            end
        end
        avail = 4'b0001;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++; if (valid !== 1'b1 || vc !== 4'b0001) begin n_fail++; $display("FAIL mask_vc0[%0d]: got valid=%b vc=%b want 1/0001", k, valid, vc); end
            take_exp(vc, found, ed);
            n_checks++; if (!found || data !== ed) begin n_fail++; $display("FAIL mask_data0[%0d]: got %h want %h", k, data, ed); end
        end
    endtask

    task automatic test_full_simul();
        bit          found;
        logic [63:0] ed;
        do_reset();
        for (int i = 0; i < 4; i++) push_flit(2'd3, 64'h300 + 64'(i));
        s_valid = 1'b1; s_vc = 2'd3; s_data = 64'h304; avail = 4'b1000; #1;
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL simul_refused: got s_ready=%b want 0", s_ready); end
        tick();
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL simul_freed: got s_ready=%b want 1", s_ready); end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                if (k == 1) tick(); else begin s_valid = 1'b0; tick(); end
            end
            if (k == 1) s_valid = 1'b0;
            n_checks++; if (valid !== 1'b1 || vc !== 4'b1000) begin n_fail++; $display("FAIL simul_vc[%0d]: got valid=%b vc=%b want 1/1000", k, valid, vc); end
            take_exp(vc, found, ed);
            n_checks++; if (!found || data !== ed || data !== 64'h300 + 64'(k)) begin n_fail++; $display("FAIL simul_data[%0d]: got %h want %h", k, data, 64'h300 + 64'(k)); end
        end
        tick();
        n_checks++; if (valid !== 1'b0 || exp_q.size() != 0) begin n_fail++; $display("FAIL simul_end: got valid=%b pending=%0d want 0/0", valid, exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) push_flit(2'd0, 64'h500 + 64'(i));
        push_flit(2'd2, 64'h520); push_flit(2'd2, 64'h521);
        avail = 4'b1111;
        tick();
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", valid); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (valid !== 1'b0 || vc !== 4'b0000 || data !== 64'h0) begin n_fail++; $display("FAIL mid_async: got valid=%b vc=%b data=%h want 0/0000/0", valid, vc, data); end
        exp_q.delete();
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale[%0d]: got valid=%b vc=%b want 0", k, valid, vc); end
        end
`ifdef VC_AVAIL_VALID_TX_STATS_EN
        n_checks++; if (sent_count !== 64'h0) begin n_fail++; $display("FAIL mid_sent_count: got %h want 0", sent_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_round_robin();
        test_avail_mask();
        test_full_simul();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vc_avail_valid_tx_buffer.md
Name: vc_avail_valid_tx_buffer

Overview:
- Parametrised multi-VC transmit stage. Accepts flits from a valid/ready source tagged with a VC id and buffers them in per-VC FIFOs.
- Sends them onto a NoC link that uses the avail/valid handshake, with one avail bit per VC.
- Round-robin arbitration across VCs that are both non-empty and available; registered link outputs.
- Successor of the single-valid avail/valid link interface: adds buffering, VC tagging and fair arbitration.

Parameters:
- FlitWidth, 64, flit payload bits.
- NumberOfVirtualChannels, 4, VC count; legal range 1..16.
- FifoDepth, 4, entries per VC FIFO; power of two, >= 2.
- VcIdWidth, $clog2(NumberOfVirtualChannels) (min 1), derived, not overridable.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  source flit valid.
- s_ready  output  1  source flit accepted when s_valid && s_ready.
- s_data  input  FlitWidth  source flit.
- s_vc  input  VcIdWidth  target VC of source flit.
- valid  output  1  link flit valid (registered).
- data  output  FlitWidth  link flit (registered).
- vc  output  NumberOfVirtualChannels  one-hot VC of link flit (registered); all zero when valid=0.
- avail  input  NumberOfVirtualChannels  per-VC downstream availability.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: valid=0, data=0, vc=0, all FIFOs empty, round-robin pointer=0. s_ready is combinational and therefore reflects the empty FIFOs while reset is held.
- s_ready = !full[s_vc]. It depends only on s_vc and FIFO state, never on s_valid.
- If s_vc >= NumberOfVirtualChannels, then s_ready=0 and the flit is never accepted.
- Write: when s_valid && s_ready, push s_data into FIFO[s_vc] at that edge. The flit is eligible for arbitration the next cycle. Minimum latency from source acceptance to valid=1 is 2 cycles.
- Avail contract: avail[v]=1 sampled at edge t guarantees that downstream accepts one flit on VC v presented at t+1. Downstream must deassert avail[v] one cycle ahead of running out of space.
- Arbitration, each cycle:
  - eligible[v] = !empty[v] && avail[v].
  - Grant the first eligible VC starting at the rr pointer, wrapping modulo NumberOfVirtualChannels.
  - On grant g: pop FIFO[g]; at the next edge valid=1, data=head, vc=onehot(g); rr pointer = (g+1) mod N.
  - With no grant: valid=0, vc=0, data holds its last value, pointer unchanged.
- Throughput: one flit per cycle total. Back-to-back flits are allowed when avail stays high.
- Simultaneous push and pop on the same VC:
  - Legal, including when the FIFO is full. s_ready stays 0 when full; the pop frees the slot only for the next cycle.
  - An empty FIFO pushed this cycle is not eligible this cycle; there is no bypass.
- Wrap-around: FIFO pointers are log2(FifoDepth)+1 bits. Full when the MSBs differ and the rest are equal.
- Flit order is preserved within a VC. There is no ordering guarantee across VCs.
- Reset asserted mid-operation: FIFO contents are discarded, outputs go to reset values immediately (asynchronously), and the pointer returns to 0.

Optional Feature:
- Macro VC_AVAIL_VALID_TX_STATS_EN.
- Defined:
  - Adds output port sent_count, width NumberOfVirtualChannels*16.
  - One 16-bit saturating counter per VC, incremented in the cycle valid=1 with vc[v]=1. The counter holds at 16'hFFFF.
  - Counters reset to 0.
- Undefined: the port and the counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then single flit s_vc=2, data=0xA5, avail=4'b1111 -> valid=1, vc=4'b0100, data=0xA5 exactly 2 cycles after acceptance; valid=0 the following cycle.
- Fill VC0 with 4 flits while avail=0 -> s_ready=0 when s_vc=0 after the 4th push; s_ready=1 for s_vc=1. Raise avail[0] -> 4 consecutive valid cycles, in order.
- VCs 0..3 each hold 2 flits, avail=4'b1111 -> output vc sequence 0001,0010,0100,1000,0001,0010,0100,1000 (round-robin fairness).
- VCs 0 and 1 loaded, avail=4'b0010 -> only vc=0010 flits sent; VC0 is held until avail[0]=1.
- VC3 full, with simultaneous push attempt on s_vc=3 and pop of VC3 -> push refused that cycle, accepted the next; no flit lost or duplicated.
- rst_n pulsed low mid-burst -> valid drops to 0 immediately; after release no stale flits appear. With VC_AVAIL_VALID_TX_STATS_EN, sent_count reads 0.
